// File: rtl/alu_exec_stage.sv
// Execute/writeback stage in front of reg_file: issues register reads, computes the
// ALU result with E/WB operand forwarding, and drives the reg_file write port.
module alu_exec_stage #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  output logic [AW-1:0] r1_addr,
  output logic [AW-1:0] r2_addr,
  input  logic [W-1:0]  r1_out,
  input  logic [W-1:0]  r2_out,
  output logic [AW-1:0] write_addr,
  output logic [W-1:0]  write_data,
  output logic          write_ctrl,
  output logic          busy
);

  localparam int unsigned SHW = $clog2(W);
  localparam int unsigned CW  = $clog2(W);

  typedef enum logic [1:0] {IDLE, EXEC, MUL_RUN} state_t;
  typedef enum logic [1:0] {SEL_RF, SEL_E, SEL_WB} sel_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
  } op_t;

  state_t        state, state_d;
  op_t           e_op, e_op_d;
  logic [AW-1:0] e_rd, e_rd_d;
  sel_t          sel1, sel1_d, sel2, sel2_d;
  logic [W-1:0]  fwd1, fwd1_d, fwd2, fwd2_d;
  logic          mul_load, mul_load_d;
  logic [CW-1:0] mul_cnt, mul_cnt_d;
  logic [W-1:0]  mul_a, mul_a_d, mul_b, mul_b_d, mul_acc, mul_acc_d;
  logic [AW-1:0] write_addr_d;
  logic [W-1:0]  write_data_d;
  logic          write_ctrl_d, busy_d, in_ready_d;

  logic [W-1:0]  op1_c, op2_c, mul_acc_nxt_c, exe_result_c;
  logic          mul_last_c, e_done_c, transfer_c, in_is_mul_c;

  assign r1_addr = in_rs1;
  assign r2_addr = in_rs2;

  // Forward select for one source: the E-stage result beats the pending WB write.
  function automatic sel_t pick_sel(input logic [AW-1:0] rs, input logic e_done,
                                    input logic [AW-1:0] erd, input logic wctrl,
                                    input logic [AW-1:0] waddr);
    if (e_done && rs == erd)      return SEL_E;
    else if (wctrl && rs == waddr) return SEL_WB;
    else                           return SEL_RF;
  endfunction

  assign op1_c         = (sel1 == SEL_RF) ? r1_out : fwd1;
  assign op2_c         = (sel2 == SEL_RF) ? r2_out : fwd2;
  assign mul_acc_nxt_c = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_last_c    = (state == MUL_RUN) && !mul_load && (mul_cnt == CW'(W - 1));
  assign e_done_c      = (state == EXEC) || mul_last_c;
  assign transfer_c    = in_valid && in_ready;
  assign in_is_mul_c   = (op_t'(in_op) == OP_MUL);

  always_comb begin
    exe_result_c = '0;
    unique case (e_op)
      OP_ADD:  exe_result_c = op1_c + op2_c;
      OP_SUB:  exe_result_c = op1_c - op2_c;
      OP_AND:  exe_result_c = op1_c & op2_c;
      OP_OR:   exe_result_c = op1_c | op2_c;
      OP_XOR:  exe_result_c = op1_c ^ op2_c;
      OP_SHL:  exe_result_c = op1_c << op2_c[SHW-1:0];
      OP_SHR:  exe_result_c = op1_c >> op2_c[SHW-1:0];
      OP_MUL:  exe_result_c = mul_acc_nxt_c;
      default: exe_result_c = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state;
    e_op_d       = e_op;
    e_rd_d       = e_rd;
    sel1_d       = sel1;
    sel2_d       = sel2;
    fwd1_d       = fwd1;
    fwd2_d       = fwd2;
    mul_load_d   = mul_load;
    mul_cnt_d    = mul_cnt;
    mul_a_d      = mul_a;
    mul_b_d      = mul_b;
    mul_acc_d    = mul_acc;
    write_addr_d = write_addr;
    write_data_d = write_data;
    write_ctrl_d = e_done_c;
    busy_d       = busy;
    in_ready_d   = in_ready;

    if (e_done_c) begin
      write_addr_d = e_rd;
      write_data_d = exe_result_c;
    end

    // Shift-add multiplier: first cycle captures operands, then one bit per edge.
    if (state == MUL_RUN) begin
      if (mul_load) begin
        mul_a_d    = op1_c;
        mul_b_d    = op2_c;
        mul_acc_d  = '0;
        mul_cnt_d  = '0;
        mul_load_d = 1'b0;
      end else if (!mul_last_c) begin
        mul_acc_d = mul_acc_nxt_c;
        mul_a_d   = mul_a << 1;
        mul_b_d   = mul_b >> 1;
        mul_cnt_d = mul_cnt + CW'(1);
        if (mul_cnt == CW'(W - 2)) in_ready_d = 1'b1;
      end
    end

    if (transfer_c) begin
      e_op_d     = op_t'(in_op);
      e_rd_d     = in_rd;
      sel1_d     = pick_sel(in_rs1, e_done_c, e_rd, write_ctrl, write_addr);
      sel2_d     = pick_sel(in_rs2, e_done_c, e_rd, write_ctrl, write_addr);
      fwd1_d     = (sel1_d == SEL_E) ? exe_result_c : write_data;
      fwd2_d     = (sel2_d == SEL_E) ? exe_result_c : write_data;
      state_d    = in_is_mul_c ? MUL_RUN : EXEC;
      mul_load_d = in_is_mul_c;
      busy_d     = in_is_mul_c;
      in_ready_d = !in_is_mul_c;
    end else if (e_done_c) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      e_op       <= OP_ADD;
      e_rd       <= '0;
      sel1       <= SEL_RF;
      sel2       <= SEL_RF;
      fwd1       <= '0;
      fwd2       <= '0;
      mul_load   <= 1'b0;
      mul_cnt    <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_acc    <= '0;
      write_addr <= '0;
      write_data <= '0;
      write_ctrl <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_d;
      e_op       <= e_op_d;
      e_rd       <= e_rd_d;
      sel1       <= sel1_d;
      sel2       <= sel2_d;
      fwd1       <= fwd1_d;
      fwd2       <= fwd2_d;
      mul_load   <= mul_load_d;
      mul_cnt    <= mul_cnt_d;
      mul_a      <= mul_a_d;
      mul_b      <= mul_b_d;
      mul_acc    <= mul_acc_d;
      write_addr <= write_addr_d;
      write_data <= write_data_d;
      write_ctrl <= write_ctrl_d;
      busy       <= busy_d;
      in_ready   <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: reg_file model, architectural golden model and a write scoreboard.
module tb_alu_exec_stage;
  localparam int unsigned W  = 8;
  localparam int unsigned AW = 8;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [AW-1:0] r1_addr, r2_addr, write_addr;
  logic [W-1:0]  r1_out = '0, r2_out = '0, write_data;
  logic          write_ctrl, busy;

  alu_exec_stage #(.W(W), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_out(r1_out), .r2_out(r2_out),
    .write_addr(write_addr), .write_data(write_data), .write_ctrl(write_ctrl),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // reg_file model: registered reads (old data on same-edge write), bench preload port
  logic [W-1:0]  rf [0:(1<<AW)-1] = '{default: '0};
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;
  always @(posedge clock) begin
    r1_out <= rf[r1_addr];
    r2_out <= rf[r2_addr];
    if (write_ctrl) rf[write_addr] <= write_data;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            cyc;
  } exp_t;
  exp_t       q[$];
  logic [W-1:0] gold [0:(1<<AW)-1];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [$clog2(W)-1:0] sh;
    logic [2*W-1:0] p;
    sh = b[$clog2(W)-1:0];
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      SHL:     return a << sh;
      SHR:     return a >> sh;
      default: return p[W-1:0];
    endcase
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; gold[a] = d;
    @(posedge clock);
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Drive one instruction from a negedge; returns on the negedge after its transfer edge.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input bit expect_write);
    int n;
    int ct;
    logic [W-1:0] res;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("issue_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    ct = cyc;
    if (expect_write) begin
      res = alu(op, gold[rs1], gold[rs2]);
      gold[rd] = res;
      q.push_back('{addr: rd, data: res, cyc: ct + ((op == MUL) ? 1 + int'(W) : 1)});
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) gold[i] = '0;

    // write-port scoreboard
    fork
      forever begin
        @(negedge clock);
        if (reset_n && write_ctrl) begin
          if (q.size() == 0) begin
            check("spurious_write", 32'(write_ctrl), 32'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("wr_addr", 32'(write_addr), 32'(e.addr));
            check("wr_data", 32'(write_data), 32'(e.data));
            check("wr_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    join_none

    repeat (3) @(negedge clock);
    check("rst_write_ctrl", 32'(write_ctrl), 32'd0);
    check("rst_write_addr", 32'(write_addr), 32'd0);
    check("rst_write_data", 32'(write_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_write_ctrl", 32'(write_ctrl), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
    end

    preload(1, 8'd5);
    preload(2, 8'd3);
    idle(2);

    issue(ADD, 3, 1, 2, 1);
    @(negedge clock);
    check("add_write_ctrl", 32'(write_ctrl), 32'd1);
    check("add_write_addr", 32'(write_addr), 32'd3);
    check("add_write_data", 32'(write_data), 32'h08);
    idle(2);

    issue(SUB, 4, 2, 1, 1);
    @(negedge clock);
    check("sub_write_data", 32'(write_data), 32'hFE);
    idle(2);

    // dependent chain: E forward, E forward on both sources, WB forward
    issue(ADD, 3, 1, 2, 1);
    issue(XOR_, 5, 3, 3, 1);
    issue(SUB, 6, 3, 1, 1);
    idle(4);
    check("gold_r6", 32'(gold[6]), 32'h03);

    // MUL then a dependent ADD held valid through the stall
    issue(MUL, 7, 1, 2, 1);
    in_valid = 1'b1; in_op = ADD; in_rd = 8'd8; in_rs1 = 8'd7; in_rs2 = 8'd1;
    for (int k = 0; k < int'(W); k++) begin
      check("mul_in_ready_low", 32'(in_ready), 32'd0);
      check("mul_busy_high", 32'(busy), 32'd1);
      @(negedge clock);
    end
    check("mul_done_in_ready", 32'(in_ready), 32'd1);
    check("mul_done_busy", 32'(busy), 32'd1);
    issue(ADD, 8, 7, 1, 1);
    check("after_mul_busy", 32'(busy), 32'd0);
    check("mul_write_data", 32'(write_data), 32'd15);
    @(negedge clock);
    check("dep_add_write_data", 32'(write_data), 32'd20);
    idle(3);

    preload(1, 8'h81);
    preload(2, 8'd9);
    idle(1);
    issue(SHL, 9, 1, 2, 1);
    issue(SHR, 10, 1, 2, 1);
    issue(AND_, 11, 1, 2, 1);
    issue(OR_, 12, 1, 2, 1);
    idle(4);
    check("gold_shl", 32'(gold[9]), 32'h02);
    check("gold_shr", 32'(gold[10]), 32'h40);

    // reset mid-MUL at counter value 3: no write may ever appear
    issue(MUL, 7, 1, 2, 0);
    repeat (4) @(negedge clock);
    check("abort_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_write_ctrl", 32'(write_ctrl), 32'd0);
    check("abort_write_addr", 32'(write_addr), 32'd0);
    check("abort_write_data", 32'(write_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    idle(12);
    check("abort_r7_kept", 32'(rf[7]), 32'd15);
    issue(ADD, 13, 1, 2, 1);
    @(negedge clock);
    check("post_abort_add", 32'(write_data), 32'h8A);
    idle(5);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute/writeback stage that sits directly in front of reg_file and around it.
- Accepts decoded instructions over a valid/ready handshake and drives reg_file read addresses.
- Consumes the registered r1_out/r2_out operands, computes an ALU result, and drives reg_file's write port (write_addr/write_data/write_ctrl).
- Forwards results internally so back-to-back dependent instructions never stall; only MUL stalls.

Parameters:
W, 8, data width (16 for use with reg_file_16b)
AW, 8, register address width (16 for reg_file_16b)

Ports:
clock  input  1  single clock; all state updates on posedge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  instruction valid
in_ready  output  1  stage can accept; a transfer occurs on a posedge with in_valid&&in_ready
in_op  input  3  opcode
in_rd  input  AW  destination register
in_rs1  input  AW  source register 1
in_rs2  input  AW  source register 2
r1_addr  output  AW  to reg_file; combinational copy of in_rs1
r2_addr  output  AW  to reg_file; combinational copy of in_rs2
r1_out  input  W  from reg_file; valid the cycle after the transfer edge
r2_out  input  W  from reg_file
write_addr  output  AW  to reg_file, registered
write_data  output  W  to reg_file, registered
write_ctrl  output  1  to reg_file, registered write enable
busy  output  1  high while a MUL is iterating

Behaviour:
- Reset (async, reset_n=0):
  - write_ctrl=0, write_addr=0, write_data=0, busy=0, in_ready=1.
  - E stage invalid; forward flags cleared.
  - Reset during a MUL aborts it; no write is ever issued for the aborted instruction.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
  - ADD/SUB/MUL keep the low W bits; there are no flags.
  - SHL/SHR shift amount is op2[$clog2(W)-1:0]; shifting fills with 0.
- Pipeline for a transfer at edge t:
  - Edge t: reg_file samples r1_addr/r2_addr. E latches op, rd, and the forward selects.
  - Cycle t+1: operands valid; E computes exe_result combinationally.
  - Edge t+1 (non-MUL): write_addr=rd, write_data=exe_result, write_ctrl=1.
  - reg_file commits at edge t+2. Issue rate is 1 instruction/cycle.
  - write_ctrl=0 in any cycle with no completing instruction.
- Forwarding, evaluated per source at the transfer edge:
  - rsX == rd of the instruction completing in E this cycle: latch exe_result into fwdX, selX=E.
  - Otherwise, rsX == write_addr with write_ctrl=1: latch write_data, selX=WB.
  - Otherwise selX=RF.
  - E match has priority over WB match. Operand X = (selX==RF) ? rX_out : fwdX.
  - rs1==rs2 is handled independently per source.
- State machine: IDLE (E empty), EXEC (single-cycle op in E), MUL_RUN.
  - IDLE/EXEC -> EXEC on transfer of a non-MUL op.
  - IDLE/EXEC -> MUL_RUN on transfer of a MUL.
  - EXEC -> IDLE when there is no transfer.
  - MUL_RUN:
    - Cycle t+1 latches the operands.
    - Then W shift-add iterations, one per edge, on a counter 0..W-1.
    - busy=1 from edge t until the result is registered.
    - in_ready=0 from edge t through the cycle before completion.
    - On the completion cycle (counter==W-1), exe_result=product and in_ready=1.
    - At that edge the result is written to WB; a simultaneous transfer is accepted and forwards from it.
    - Next state is EXEC/MUL_RUN if a transfer occurred, else IDLE.
  - MUL latency: write_ctrl asserts after edge t+1+W.
- in_valid while in_ready=0 is ignored. Upstream holds in_op, in_rd, in_rs1 and in_rs2 stable.

Test Plan:
- Reset then idle, with in_valid=0 for 10 cycles -> write_ctrl stays 0, in_ready=1; the reg_file outputs are ignored.
- Preload R1=5, R2=3. Issue ADD R3,R1,R2 -> one cycle later write_ctrl=1, write_addr=3, write_data=8. Repeat with SUB R4,R2,R1 -> write_data=0xFE (W=8).
- Back-to-back dependency: ADD R3,R1,R2 then XOR R5,R3,R3 then SUB R6,R3,R1 on consecutive cycles -> writes 8, 0, 3 on consecutive cycles with no bubble. This exercises the E-forward, E-forward on both sources, and the WB-forward paths.
- MUL R7,R1,R2 followed immediately by ADD R8,R7,R1 held valid:
  - in_ready=0 and busy=1 for W cycles.
  - write R7=15 lands at cycle t+1+W.
  - ADD is accepted at completion and writes R8=20 the next cycle.
- Shifts with R1=0x81, R2=9: SHL R9,R1,R2 -> 0x02; SHR R10,R1,R2 -> 0x40 (amount 1).
- Assert reset_n=0 at MUL iteration 3 -> outputs return to reset values immediately. After release, no write to R7 occurs and the next ADD executes normally.
